// File: rtl/numdisp_pkg.sv
// Shared types and constants for the number display scheduler.
package numdisp_pkg;

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    localparam int CX_DEF = 320;
    localparam int CY_DEF = 240;
    localparam int HOLD_W = 8;
    localparam int SLOT_W = 3;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: next set request strictly after i_cur, wrapping to 0.
// i_cur itself is found last, so a lone requester is re-granted.
module rr_pick
    import numdisp_pkg::*;
#(
    parameter int NSLOTS = 4
) (
    input  logic [NSLOTS-1:0] i_req,
    input  logic [SLOT_W-1:0] i_cur,
    output logic [SLOT_W-1:0] o_next,
    output logic              o_any
);

    logic [2*NSLOTS-1:0] w_dbl;
    logic [NSLOTS-1:0]   w_rot;
    int                  w_off;

    // Bit j of w_rot is slot (i_cur + 1 + j) mod NSLOTS.
    assign w_dbl = {i_req, i_req} >> ({1'b0, i_cur} + 4'd1);
    assign w_rot = w_dbl[NSLOTS-1:0];
    assign o_any = |i_req;

    always_comb begin
        w_off = 0;
        for (int j = NSLOTS - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = j;
        end
    end

    assign o_next = SLOT_W'((int'(i_cur) + 1 + w_off) % NSLOTS);

endmodule

// File: rtl/number_display_scheduler.sv
// Frame-synchronous scheduler sharing one 4-digit renderer between NSLOTS requesters.
// Optional NUMBER_SCHED_FREEZE_EN adds a freeze input that pauses hold countdown and switching.
module number_display_scheduler
    import numdisp_pkg::*;
#(
    parameter int NSLOTS      = 4,
    parameter int HOLD_FRAMES = 60,
    parameter int CX          = CX_DEF,
    parameter int CY          = CY_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
`ifdef NUMBER_SCHED_FREEZE_EN
    input  logic                 freeze,
`endif
    input  logic [NSLOTS-1:0]    req,
    input  logic [16*NSLOTS-1:0] value,
    output logic [NSLOTS-1:0]    ack,
    output logic [15:0]          number,
    output logic [10:0]          cx,
    output logic [10:0]          cy,
    output logic [2:0]           slot,
    output logic                 blank
);

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic [HOLD_W-1:0]   r_hold;
    logic [15:0]         r_number;
    logic [NSLOTS-1:0]   r_ack;

    logic                w_freeze;
    logic [SLOT_W-1:0]   w_cur;
    logic [SLOT_W-1:0]   w_next;
    logic                w_any;
    logic [15:0]         w_cur_val;
    logic [15:0]         w_next_val;
    logic                w_cur_req;
    logic [NSLOTS-1:0]   w_next_oh;

`ifdef NUMBER_SCHED_FREEZE_EN
    assign w_freeze = freeze;
`else
    assign w_freeze = 1'b0;
`endif

    // From IDLE, searching after the last slot yields the lowest-index requester.
    assign w_cur = (r_state == IDLE) ? SLOT_W'(NSLOTS - 1) : r_slot;

    rr_pick #(.NSLOTS(NSLOTS)) u_rr_pick (
        .i_req  (req),
        .i_cur  (w_cur),
        .o_next (w_next),
        .o_any  (w_any)
    );

    always_comb begin
        w_cur_val  = '0;
        w_next_val = '0;
        w_cur_req  = 1'b0;
        w_next_oh  = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_cur_val = value[16*i +: 16];
                w_cur_req = req[i];
            end
            if (w_next == SLOT_W'(i)) begin
                w_next_val   = value[16*i +: 16];
                w_next_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_slot   <= '0;
            r_hold   <= '0;
            r_number <= '0;
            r_ack    <= '0;
        end else begin
            r_ack <= '0;
            if (frame_start) begin
                if (r_state == SHOW && (w_freeze || r_hold != '0)) begin
                    if (!w_freeze) r_hold <= r_hold - 1'b1;
                    if (w_cur_req) r_number <= w_cur_val;
                end else if (w_any) begin
                    r_state  <= SHOW;
                    r_slot   <= w_next;
                    r_number <= w_next_val;
                    r_hold   <= HOLD_W'(HOLD_FRAMES - 1);
                    r_ack    <= w_next_oh;
                end else begin
                    r_state  <= IDLE;
                    r_slot   <= '0;
                    r_number <= '0;
                    r_hold   <= '0;
                end
            end
        end
    end

    assign ack    = r_ack;
    assign number = r_number;
    assign slot   = r_slot;
    assign blank  = (r_state == IDLE);
    assign cx     = 11'(CX);
    assign cy     = 11'(CY);

endmodule

// File: tb/tb_number_display_scheduler.sv
// Randomized and directed bench for number_display_scheduler against a frame-level reference model.
module tb_number_display_scheduler;

    localparam int N  = 4;
    localparam int HF = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fs = 1'b0;
    logic          freeze = 1'b0;
    logic [N-1:0]  req = '0;
    logic [16*N-1:0] value = '0;
    logic [N-1:0]  ack;
    logic [15:0]   number;
    logic [10:0]   cx, cy;
    logic [2:0]    slot;
    logic          blank;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frames left on screen rather than a down-counter.
    bit          m_show;
    int          m_slot, m_left;
    logic [15:0] m_num;
    logic [N-1:0] m_ack;

    logic [15:0] d_num;
    logic [2:0]  d_slot;
    logic [N-1:0] d_ack;
    logic        d_blank;

    number_display_scheduler #(.NSLOTS(N), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .rst(rst), .frame_start(fs),
`ifdef NUMBER_SCHED_FREEZE_EN
        .freeze(freeze),
`endif
        .req(req), .value(value), .ack(ack), .number(number),
        .cx(cx), .cy(cy), .slot(slot), .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic grant(input int i);
        m_show = 1;
        m_slot = i;
        m_left = HF;
        m_num  = value[16*i +: 16];
        m_ack  = N'(1 << i);
    endtask

    task automatic model_edge();
        int nx;
        m_ack = '0;
        if (!rst) begin
            m_show = 0; m_slot = 0; m_left = 0; m_num = '0;
        end else if (fs) begin
            if (!m_show) begin
                nx = -1;
                for (int i = N - 1; i >= 0; i--) if (req[i]) nx = i;
                if (nx >= 0) grant(nx);
            end else begin
                if (!freeze) m_left--;
                if (m_left > 0) begin
                    if (req[m_slot]) m_num = value[16*m_slot +: 16];
                end else begin
                    nx = -1;
                    for (int k = N; k >= 1; k--) if (req[(m_slot + k) % N]) nx = (m_slot + k) % N;
                    if (nx >= 0) grant(nx);
                    else begin
                        m_show = 0; m_slot = 0; m_num = '0;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("number", number, m_num);
        chk("ack", ack, m_ack);
        chk("slot", slot, m_slot);
        chk("blank", blank, !m_show);
    endtask

    // One frame: a frame_start cycle followed by gap blanking/active cycles.
    task automatic frame(input int gap, input bit jitter);
        fs = 1'b1;
        step();
        d_num = number; d_slot = slot; d_ack = ack; d_blank = blank;
        fs = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (jitter) begin
                req = N'($urandom);
                value[16*($urandom_range(0, N-1)) +: 16] = 16'($urandom);
            end
            step();
        end
    endtask

    logic [2:0] seq [5];
    logic [2:0] exp_seq [5];

    initial begin
        exp_seq[0] = 3'd0; exp_seq[1] = 3'd0; exp_seq[2] = 3'd3; exp_seq[3] = 3'd3; exp_seq[4] = 3'd0;

        rst = 1'b0;
        step(); step();
        chk("cx", cx, 32'd320);
        chk("cy", cy, 32'd240);
        rst = 1'b1;
        for (int f = 0; f < 5; f++) frame(3, 1'b0);
        chk("idle_blank", d_blank, 1'b1);

        req = 4'b0010; value[31:16] = 16'hBEEF;
        frame(3, 1'b0);
        chk("beef_slot", d_slot, 3'd1);
        chk("beef_num", d_num, 16'hBEEF);
        chk("beef_ack", d_ack, 4'b0010);
        chk("beef_blank", d_blank, 1'b0);
        req = '0;
        frame(2, 1'b0); frame(2, 1'b0);
        chk("beef_idle", d_blank, 1'b1);

        req = 4'b1001; value[15:0] = 16'h1111; value[63:48] = 16'h3333;
        for (int f = 0; f < 5; f++) begin
            frame(2, 1'b0);
            seq[f] = d_slot;
        end
        for (int f = 0; f < 5; f++) chk($sformatf("rr_seq%0d", f), seq[f], exp_seq[f]);
        chk("rr_wrap_num", d_num, 16'h1111);
        req = '0;
        frame(2, 1'b0); frame(2, 1'b0);

        req = 4'b0100; value[47:32] = 16'h2222;
        frame(2, 1'b0);
        req = '0; value[47:32] = 16'h9999;
        frame(2, 1'b0);
        chk("drop_hold", d_num, 16'h2222);
        frame(2, 1'b0);
        chk("drop_idle", d_blank, 1'b1);
        chk("drop_num", d_num, 16'h0000);

        req = 4'b0001;
        frame(2, 1'b0);
        rst = 1'b0; fs = 1'b1;
        step();
        chk("rst_fs_num", number, 16'h0000);
        chk("rst_fs_ack", ack, 4'b0000);
        chk("rst_fs_blank", blank, 1'b1);
        rst = 1'b1; fs = 1'b0;
        step();

`ifdef NUMBER_SCHED_FREEZE_EN
        req = 4'b0011; value[15:0] = 16'h0A00;
        frame(2, 1'b0);
        freeze = 1'b1;
        for (int f = 0; f < 10; f++) begin
            value[15:0] = 16'h0A00 + 16'(f + 1);
            frame(2, 1'b0);
            chk("frz_slot", d_slot, 3'd0);
            chk("frz_num", d_num, 16'h0A00 + 16'(f + 1));
        end
        freeze = 1'b0;
        frame(2, 1'b0);
`endif

        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0; step(); rst = 1'b1;
            end
            req = N'($urandom);
            for (int i = 0; i < N; i++) value[16*i +: 16] = 16'($urandom);
`ifdef NUMBER_SCHED_FREEZE_EN
            freeze = ($urandom_range(0, 3) == 0);
`endif
            frame($urandom_range(1, 4), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
